// File: rtl/clk_switch_ctrl.sv
// Sequencer for an N-input glitch-free clock switch: owns sel, serialises requests, auto-fails-over.
// Latency: sel moves 1 cycle after accept; done 1 cycle after reject/same-sel or WAIT_CYC+1 after a switch.
// Backpressure: req_ready low during the settle window, in NOCLK, and on a same-cycle failover event.
module clk_switch_ctrl #(
   parameter int CLK_NUM     = 4,
   parameter int SEL_W       = $clog2(CLK_NUM),
   parameter int WAIT_CYC    = 16,
   parameter int DEFAULT_SEL = 0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [CLK_NUM-1:0] clk_fail,
   input  logic               req_valid,
   input  logic [SEL_W-1:0]   req_sel,
   output logic               req_ready,
   output logic               done_valid,
   output logic               done_err,
   output logic [SEL_W-1:0]   sel,
   output logic               switching,
   output logic               all_fail,
   output logic               fail_irq
);

   // Counter holds WAIT_CYC-1 down to 0; at least one bit even for WAIT_CYC==1.
   localparam int CNT_W = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYC - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_NOCLK = 2'd2
   } state_t;

   state_t             state_q;
   logic [CLK_NUM-1:0] fail_m_q;
   logic [CLK_NUM-1:0] fail_s_q;
   logic [SEL_W-1:0]   sel_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               pend_q;
   logic               done_valid_q;
   logic               done_err_q;
   logic               switching_q;
   logic               all_fail_q;
   logic               fail_irq_q;

   logic               sel_failed;
   logic               req_ok;
   logic               any_ok;
   logic [SEL_W-1:0]   low_ok;
   logic               fo_evt;
   logic               accept;

   // Two-flop synchroniser for the asynchronous monitor fail flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fail_m_q <= '0;
         fail_s_q <= '0;
      end else begin
         fail_m_q <= clk_fail;
         fail_s_q <= fail_m_q;
      end
   end

   // Health decode: current-sel failure, request target validity, lowest healthy index.
   // Explicit compares avoid indexing fail_s_q with an out-of-range select.
   always_comb begin
      sel_failed = 1'b0;
      req_ok     = 1'b0;
      any_ok     = 1'b0;
      low_ok     = '0;
      for (int i = CLK_NUM - 1; i >= 0; i--) begin
         if (!fail_s_q[i]) begin
            any_ok = 1'b1;
            low_ok = SEL_W'(i);
         end
         if ((sel_q == SEL_W'(i)) && fail_s_q[i]) sel_failed = 1'b1;
         if ((req_sel == SEL_W'(i)) && !fail_s_q[i]) req_ok = 1'b1;
      end
   end

   assign fo_evt    = (state_q != ST_NOCLK) && sel_failed;
   assign req_ready = (state_q == ST_IDLE) && !fo_evt;
   assign accept    = req_valid && req_ready;

   // Main sequencer: failover outranks requests; all outputs registered here.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         sel_q        <= SEL_W'(DEFAULT_SEL);
         cnt_q        <= '0;
         pend_q       <= 1'b0;
         done_valid_q <= 1'b0;
         done_err_q   <= 1'b0;
         switching_q  <= 1'b0;
         all_fail_q   <= 1'b0;
         fail_irq_q   <= 1'b0;
      end else begin
         done_valid_q <= 1'b0;
         done_err_q   <= 1'b0;
         fail_irq_q   <= 1'b0;
         case (state_q)
            ST_IDLE, ST_WAIT: begin
               if (fo_evt) begin
                  // Abort any pending request in the same cycle as the irq.
                  fail_irq_q   <= 1'b1;
                  done_valid_q <= pend_q;
                  done_err_q   <= pend_q;
                  pend_q       <= 1'b0;
                  if (any_ok) begin
                     sel_q       <= low_ok;
                     cnt_q       <= CNT_LOAD;
                     switching_q <= 1'b1;
                     state_q     <= ST_WAIT;
                  end else begin
                     cnt_q       <= '0;
                     switching_q <= 1'b0;
                     all_fail_q  <= 1'b1;
                     state_q     <= ST_NOCLK;
                  end
               end else if (state_q == ST_IDLE) begin
                  if (accept) begin
                     if (!req_ok) begin
                        done_valid_q <= 1'b1;
                        done_err_q   <= 1'b1;
                     end else if (req_sel == sel_q) begin
                        done_valid_q <= 1'b1;
                     end else begin
                        sel_q       <= req_sel;
                        cnt_q       <= CNT_LOAD;
                        switching_q <= 1'b1;
                        pend_q      <= 1'b1;
                        state_q     <= ST_WAIT;
                     end
                  end
               end else begin
                  if (cnt_q == '0) begin
                     state_q      <= ST_IDLE;
                     switching_q  <= 1'b0;
                     done_valid_q <= pend_q;
                     pend_q       <= 1'b0;
                  end else begin
                     cnt_q <= cnt_q - 1'b1;
                  end
               end
            end
            ST_NOCLK: begin
               // Recovery is autonomous; nobody is waiting for a done pulse.
               if (any_ok) begin
                  sel_q       <= low_ok;
                  cnt_q       <= CNT_LOAD;
                  switching_q <= 1'b1;
                  all_fail_q  <= 1'b0;
                  pend_q      <= 1'b0;
                  state_q     <= ST_WAIT;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign sel        = sel_q;
   assign done_valid = done_valid_q;
   assign done_err   = done_err_q;
   assign switching  = switching_q;
   assign all_fail   = all_fail_q;
   assign fail_irq   = fail_irq_q;

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// Directed bench for clk_switch_ctrl: requests, rejects, failover, all-fail recovery, reset abort.
// Inputs are driven and outputs sampled 1 ns after each rising edge.
// Uses SEL_W=3 so an out-of-range index (5) can be presented with CLK_NUM=4.
module tb_clk_switch_ctrl;

   localparam int CLK_NUM = 4;
   localparam int SEL_W   = 3;
   localparam int WAIT_CYC = 16;

   logic               clk = 1'b0;
   logic               rst;
   logic [CLK_NUM-1:0] clk_fail;
   logic               req_valid;
   logic [SEL_W-1:0]   req_sel;
   logic               req_ready;
   logic               done_valid;
   logic               done_err;
   logic [SEL_W-1:0]   sel;
   logic               switching;
   logic               all_fail;
   logic               fail_irq;

   int n_chk  = 0;
   int n_fail = 0;

   clk_switch_ctrl #(
      .CLK_NUM    (CLK_NUM),
      .SEL_W      (SEL_W),
      .WAIT_CYC   (WAIT_CYC),
      .DEFAULT_SEL(0)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .clk_fail  (clk_fail),
      .req_valid (req_valid),
      .req_sel   (req_sel),
      .req_ready (req_ready),
      .done_valid(done_valid),
      .done_err  (done_err),
      .sel       (sel),
      .switching (switching),
      .all_fail  (all_fail),
      .fail_irq  (fail_irq)
   );

   always #5 clk = ~clk;

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Walk the remaining window cycles (switching high, no done), then the cycle after it.
   task automatic window_rest(input string tag, input int n, input logic exp_done_after);
      for (int k = 0; k < n; k++) begin
         tick();
         chk_eq({tag, "_sw"}, switching, 1'b1);
         chk_eq({tag, "_nodone"}, done_valid, 1'b0);
         chk_eq({tag, "_rdy0"}, req_ready, 1'b0);
      end
      tick();
      chk_eq({tag, "_end_sw"}, switching, 1'b0);
      chk_eq({tag, "_end_done"}, done_valid, exp_done_after);
      chk_eq({tag, "_end_rdy"}, req_ready, 1'b1);
   endtask

   initial begin
      rst       = 1'b1;
      clk_fail  = '0;
      req_valid = 1'b0;
      req_sel   = '0;
      tick(); tick();
      // Reset state
      chk_eq("rst_sel", sel, 0);
      chk_eq("rst_sw", switching, 0);
      chk_eq("rst_done", done_valid, 0);
      chk_eq("rst_err", done_err, 0);
      chk_eq("rst_allf", all_fail, 0);
      chk_eq("rst_irq", fail_irq, 0);
      rst = 1'b0;
      tick();
      chk_eq("rst_rdy", req_ready, 1);

      // Plain switch to 2
      req_valid = 1'b1; req_sel = 3'd2;
      tick();
      req_valid = 1'b0;
      chk_eq("sw2_sel", sel, 2);
      chk_eq("sw2_sw1", switching, 1);
      chk_eq("sw2_done1", done_valid, 0);
      window_rest("sw2", WAIT_CYC - 1, 1'b1);
      chk_eq("sw2_err", done_err, 0);
      tick();
      chk_eq("sw2_pulse", done_valid, 0);

      // Same-sel request
      req_valid = 1'b1; req_sel = 3'd2;
      tick();
      req_valid = 1'b0;
      chk_eq("same_done", done_valid, 1);
      chk_eq("same_err", done_err, 0);
      chk_eq("same_sw", switching, 0);
      chk_eq("same_sel", sel, 2);
      tick();
      // Out-of-range request
      req_valid = 1'b1; req_sel = 3'd5;
      tick();
      req_valid = 1'b0;
      chk_eq("oor_done", done_valid, 1);
      chk_eq("oor_err", done_err, 1);
      chk_eq("oor_sel", sel, 2);
      chk_eq("oor_sw", switching, 0);
      tick();

      // Failover from 2 with 0 also failed -> 1
      clk_fail = 4'b0101;
      tick();
      chk_eq("fo_e1_sel", sel, 2);
      tick();
      chk_eq("fo_e2_sel", sel, 2);
      chk_eq("fo_e2_irq", fail_irq, 0);
      tick();
      chk_eq("fo_sel", sel, 1);
      chk_eq("fo_irq", fail_irq, 1);
      chk_eq("fo_sw", switching, 1);
      chk_eq("fo_done", done_valid, 0);
      tick();
      chk_eq("fo_irq_once", fail_irq, 0);
      window_rest("fo", WAIT_CYC - 2, 1'b0);
      clk_fail = '0;
      tick(); tick();

      // Request to 3, clk 3 fails mid-window -> abort, sel 0, window restart
      req_valid = 1'b1; req_sel = 3'd3;
      tick();
      req_valid = 1'b0;
      chk_eq("ab_sel3", sel, 3);
      tick(); tick(); tick(); tick();   // now in window cycle 5
      clk_fail = 4'b1000;
      tick(); tick();
      chk_eq("ab_pre_sel", sel, 3);
      chk_eq("ab_pre_done", done_valid, 0);
      tick();
      chk_eq("ab_done", done_valid, 1);
      chk_eq("ab_err", done_err, 1);
      chk_eq("ab_irq", fail_irq, 1);
      chk_eq("ab_sel", sel, 0);
      chk_eq("ab_sw", switching, 1);
      window_rest("ab", WAIT_CYC - 1, 1'b0);
      clk_fail = '0;
      tick(); tick();

      // All clocks fail
      clk_fail = 4'b1111;
      tick(); tick(); tick();
      chk_eq("nc_allf", all_fail, 1);
      chk_eq("nc_irq", fail_irq, 1);
      chk_eq("nc_rdy", req_ready, 0);
      chk_eq("nc_sel", sel, 0);
      chk_eq("nc_sw", switching, 0);
      tick();
      chk_eq("nc_irq_once", fail_irq, 0);
      clk_fail = 4'b0111;
      tick(); tick();
      chk_eq("nc_hold_allf", all_fail, 1);
      chk_eq("nc_hold_sel", sel, 0);
      tick();
      chk_eq("nc_rec_sel", sel, 3);
      chk_eq("nc_rec_allf", all_fail, 0);
      chk_eq("nc_rec_sw", switching, 1);
      window_rest("nc", WAIT_CYC - 1, 1'b0);

      // Request colliding with a failover event (sel 3 fails, 2 is the only healthy)
      clk_fail = 4'b1011;
      tick(); tick();
      req_valid = 1'b1; req_sel = 3'd2;
      #1;
      chk_eq("col_rdy", req_ready, 0);
      tick();
      chk_eq("col_sel", sel, 2);
      chk_eq("col_irq", fail_irq, 1);
      chk_eq("col_done", done_valid, 0);
      window_rest("col", WAIT_CYC - 1, 1'b0);
      tick();
      req_valid = 1'b0;
      chk_eq("col_acc_done", done_valid, 1);
      chk_eq("col_acc_err", done_err, 0);
      clk_fail = '0;
      tick(); tick();

      // Rejection of a failed target
      clk_fail = 4'b0010;
      tick(); tick();
      req_valid = 1'b1; req_sel = 3'd1;
      tick();
      req_valid = 1'b0;
      chk_eq("rjf_done", done_valid, 1);
      chk_eq("rjf_err", done_err, 1);
      chk_eq("rjf_sel", sel, 2);
      clk_fail = '0;
      tick(); tick();

      // Reset in the middle of a window: no done afterwards
      req_valid = 1'b1; req_sel = 3'd1;
      tick();
      req_valid = 1'b0;
      chk_eq("mr_sel1", sel, 1);
      tick(); tick(); tick();
      rst = 1'b1;
      #1;
      chk_eq("mr_sel", sel, 0);
      chk_eq("mr_sw", switching, 0);
      chk_eq("mr_done", done_valid, 0);
      tick();
      rst = 1'b0;
      for (int k = 0; k < WAIT_CYC + 2; k++) begin
         tick();
         chk_eq("mr_nodone", done_valid, 0);
      end
      chk_eq("mr_rdy", req_ready, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
